// File: rtl/lsu_pkg.sv
// ---------------------------------------------------------------------------
// lsu_pkg
// Shared definitions for the load/store unit: access-size encodings, the
// controller state enum, the default MMIO window base and a small helper.
// No ports; imported by the interface, the lane sub-module and the top.
// ---------------------------------------------------------------------------
package lsu_pkg;

  // Access size as carried on the request bus. SZ_BAD marks the illegal code.
  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2,
    SZ_BAD  = 2'd3
  } size_e;

  // Controller states, in the order a read-modify-write walks through them.
  typedef enum logic [2:0] {
    IDLE,
    RD,
    WAIT,
    WR,
    RESP
  } state_e;

  // Lowest MMIO address. Device registers there only accept whole-word stores.
  localparam logic [31:0] MMIO_BASE_DEFAULT = 32'hFFFF_FFF0;

  // Sub-word accesses are the ones that need lane handling.
  function automatic logic isSubWord(input size_e s);
    return (s == SZ_BYTE) || (s == SZ_HALF);
  endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// ---------------------------------------------------------------------------
// load_store_unit_if
// Request/response channel between the CPU pipeline and the load/store unit.
//   req_valid / req_ready : request handshake, accepted when both are high
//   req_we                : 1 = store, 0 = load
//   req_size              : 0 byte, 1 half, 2 word, 3 illegal
//   req_signed            : sign-extend sub-word loads
//   req_addr / req_wdata  : byte address and right-justified store data
//   resp_valid            : one-cycle response strobe (no backpressure)
//   resp_rdata / resp_err : load result (0 for stores) and error flag
// master = pipeline side, slave = load/store unit side.
// ---------------------------------------------------------------------------
interface load_store_unit_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
);

  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [1:0]        req_size;
  logic              req_signed;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              resp_valid;
  logic [DATA_W-1:0] resp_rdata;
  logic              resp_err;

  modport master (
    output req_valid, req_we, req_size, req_signed, req_addr, req_wdata,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_we, req_size, req_signed, req_addr, req_wdata,
    output req_ready, resp_valid, resp_rdata, resp_err
  );

endinterface

// File: rtl/lsu_lane.sv
// ---------------------------------------------------------------------------
// lsu_lane
// Purely combinational little-endian lane logic.
//   i_word       : word returned by memory
//   i_offset     : byte offset of the access inside that word
//   i_size       : access size
//   i_signed     : sign-extend sub-word load results
//   i_storeData  : low half of the store data (only bytes/halves are merged)
//   o_loadVal    : extracted and extended load result
//   o_mergedWord : i_word with the store byte/half inserted at i_offset
// Word accesses pass i_word through unchanged on both outputs.
// ---------------------------------------------------------------------------
module lsu_lane
  import lsu_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0] i_word,
  input  logic [1:0]        i_offset,
  input  size_e             i_size,
  input  logic              i_signed,
  input  logic [15:0]       i_storeData,
  output logic [DATA_W-1:0] o_loadVal,
  output logic [DATA_W-1:0] o_mergedWord
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  // Pick the addressed lane once, then either extend it for a load or
  // overwrite it in place for a read-modify-write store. Halves are aligned,
  // so only offset bit 1 selects between the two half lanes.
  always_comb begin
    o_loadVal    = i_word;
    o_mergedWord = i_word;
    w_byte       = i_word[{i_offset, 3'b000} +: 8];
    w_half       = i_word[{i_offset[1], 4'b0000} +: 16];
    case (i_size)
      SZ_BYTE: begin
        o_loadVal = {{(DATA_W-8){i_signed & w_byte[7]}}, w_byte};
        o_mergedWord[{i_offset, 3'b000} +: 8] = i_storeData[7:0];
      end
      SZ_HALF: begin
        o_loadVal = {{(DATA_W-16){i_signed & w_half[15]}}, w_half};
        o_mergedWord[{i_offset[1], 4'b0000} +: 16] = i_storeData;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// ---------------------------------------------------------------------------
// load_store_unit
// Memory-access stage between the CPU pipeline and a word-only memory.
// Takes one request at a time, performs sub-word loads by lane extraction and
// sub-word stores by read-modify-write, and returns one response per request.
//   clk, rst    : rising-edge clock, synchronous active-high reset
//   bus         : request/response channel (slave side)
//   memread_o   : read strobe, data comes back on memrdata_i one cycle later
//   memwrite_o  : write strobe
//   memaddr_o   : word-aligned address, holds its last value when idle
//   memwdata_o  : full-word write data
//   memrdata_i  : memory read data
// ---------------------------------------------------------------------------
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int                DATA_W    = 32,
  parameter int                ADDR_W    = 32,
  parameter logic [ADDR_W-1:0] MMIO_BASE = MMIO_BASE_DEFAULT
) (
  input  logic                clk,
  input  logic                rst,
  load_store_unit_if.slave    bus,
  output logic                memread_o,
  output logic                memwrite_o,
  output logic [ADDR_W-1:0]   memaddr_o,
  output logic [DATA_W-1:0]   memwdata_o,
  input  logic [DATA_W-1:0]   memrdata_i
);

  state_e            r_state;
  logic              r_ready;
  logic              r_respValid;
  logic              r_respErr;
  logic [DATA_W-1:0] r_respData;
  logic              r_we;
  size_e             r_size;
  logic              r_signed;
  logic [1:0]        r_offset;
  logic [15:0]       r_wdata;
  logic [ADDR_W-1:0] r_memAddr;
  logic [DATA_W-1:0] r_memWdata;

  logic              w_err;
  logic [DATA_W-1:0] w_loadVal;
  logic [DATA_W-1:0] w_mergedWord;

  // Classify the incoming request. Misaligned halves/words and the illegal
  // size code are rejected, as is any byte/half store into the MMIO window,
  // because device registers cannot tolerate the read half of a merge.
  always_comb begin
    w_err = 1'b0;
    case (size_e'(bus.req_size))
      SZ_BYTE: w_err = bus.req_we && (bus.req_addr >= MMIO_BASE);
      SZ_HALF: w_err = bus.req_addr[0] || (bus.req_we && (bus.req_addr >= MMIO_BASE));
      SZ_WORD: w_err = (bus.req_addr[1:0] != 2'b00);
      default: w_err = 1'b1;
    endcase
  end

  // Lane extraction and merge run on the raw memory data; they are only
  // consumed in the WAIT state, when memrdata_i holds the requested word.
  lsu_lane #(.DATA_W(DATA_W)) u_lane (
    .i_word       (memrdata_i),
    .i_offset     (r_offset),
    .i_size       (r_size),
    .i_signed     (r_signed),
    .i_storeData  (r_wdata),
    .o_loadVal    (w_loadVal),
    .o_mergedWord (w_mergedWord)
  );

  // Main controller. Every response-side output is registered on the edge
  // that enters RESP, so resp_valid is high for exactly the RESP cycle.
  // The aligned address is captured once at accept and reused by RD and WR.
  // A reset in any state simply drops the request: nothing is replayed.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_ready     <= 1'b1;
      r_respValid <= 1'b0;
      r_respErr   <= 1'b0;
      r_respData  <= '0;
      r_we        <= 1'b0;
      r_size      <= SZ_BYTE;
      r_signed    <= 1'b0;
      r_offset    <= 2'b00;
      r_wdata     <= '0;
      r_memAddr   <= '0;
      r_memWdata  <= '0;
    end else begin
      r_respValid <= 1'b0;
      case (r_state)
        IDLE: begin
          if (bus.req_valid && r_ready) begin
            r_ready  <= 1'b0;
            r_we     <= bus.req_we;
            r_size   <= size_e'(bus.req_size);
            r_signed <= bus.req_signed;
            r_offset <= bus.req_addr[1:0];
            r_wdata  <= bus.req_wdata[15:0];
            if (w_err) begin
              r_respValid <= 1'b1;
              r_respErr   <= 1'b1;
              r_respData  <= '0;
              r_state     <= RESP;
            end else begin
              r_memAddr <= {bus.req_addr[ADDR_W-1:2], 2'b00};
              if (!bus.req_we || isSubWord(size_e'(bus.req_size))) begin
                r_state <= RD;
              end else begin
                r_memWdata <= bus.req_wdata;
                r_state    <= WR;
              end
            end
          end
        end
        RD: r_state <= WAIT;
        WAIT: begin
          if (r_we) begin
            r_memWdata <= w_mergedWord;
            r_state    <= WR;
          end else begin
            r_respValid <= 1'b1;
            r_respErr   <= 1'b0;
            r_respData  <= w_loadVal;
            r_state     <= RESP;
          end
        end
        WR: begin
          r_respValid <= 1'b1;
          r_respErr   <= 1'b0;
          r_respData  <= '0;
          r_state     <= RESP;
        end
        RESP: begin
          r_ready <= 1'b1;
          r_state <= IDLE;
        end
        default: begin
          r_ready <= 1'b1;
          r_state <= IDLE;
        end
      endcase
    end
  end

  // Strobes are decoded from state and masked by reset so that a reset cycle
  // can never issue a memory access, whatever state it interrupts.
  assign memread_o  = (r_state == RD) && !rst;
  assign memwrite_o = (r_state == WR) && !rst;
  assign memaddr_o  = r_memAddr;
  assign memwdata_o = r_memWdata;

  assign bus.req_ready  = r_ready;
  assign bus.resp_valid = r_respValid;
  assign bus.resp_rdata = r_respData;
  assign bus.resp_err   = r_respErr;

endmodule

// File: tb/tb_load_store_unit.sv
// ---------------------------------------------------------------------------
// tb_load_store_unit
// Drives load/store requests into load_store_unit, emulates a word memory
// with one-cycle read latency, and compares every response and memory strobe
// against a byte-addressed reference model of the memory.
// ---------------------------------------------------------------------------
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        memread_o;
  logic        memwrite_o;
  logic [31:0] memaddr_o;
  logic [31:0] memwdata_o;
  logic [31:0] memrdata_i = 32'h0;

  int checks = 0;
  int errors = 0;

  load_store_unit_if #(.DATA_W(32), .ADDR_W(32)) bus ();

  load_store_unit #(
    .DATA_W   (32),
    .ADDR_W   (32),
    .MMIO_BASE(32'hFFFF_FFF0)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .memread_o  (memread_o),
    .memwrite_o (memwrite_o),
    .memaddr_o  (memaddr_o),
    .memwdata_o (memwdata_o),
    .memrdata_i (memrdata_i)
  );

  always #5 clk = ~clk;

  // Words written by the DUT; everything else reads its power-on pattern.
  logic [31:0] memWords [logic [31:0]];
  // Reference memory kept byte by byte, updated only by the model.
  logic [7:0]  refBytes [logic [31:0]];

  // Power-on memory content, with the two words the directed steps rely on.
  function automatic logic [31:0] initWord(input logic [31:0] a);
    if (a == 32'h0000_1004) return 32'hDEAD_BEEF;
    if (a == 32'h0000_1000) return 32'hAABB_CCDD;
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_5A5A;
  endfunction

  function automatic logic [31:0] busWord(input logic [31:0] a);
    if (memWords.exists(a)) return memWords[a];
    return initWord(a);
  endfunction

  function automatic logic [7:0] refByte(input logic [31:0] a);
    logic [31:0] w;
    if (refBytes.exists(a)) return refBytes[a];
    w = initWord(a & 32'hFFFF_FFFC) >> (8 * int'(a[1:0]));
    return w[7:0];
  endfunction

  // Word memory: read data appears the cycle after memread_o; at other times
  // the data bus carries junk so mistimed sampling is visible.
  always @(posedge clk) begin
    if (memread_o) memrdata_i <= busWord(memaddr_o);
    else           memrdata_i <= $urandom;
    if (memwrite_o) memWords[memaddr_o] = memwdata_o;
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One complete request: predict from the byte model, issue it, watch the
  // strobes for a bounded number of cycles and compare everything observed.
  task automatic applyStimulus(input logic we, input logic [1:0] size, input logic sgn,
                               input logic [31:0] addr, input logic [31:0] wdata,
                               input string name);
    int          n;
    logic        expErr;
    int          expLat;
    int          expReads;
    int          expWrites;
    logic [31:0] aligned;
    logic [31:0] expRdata;
    logic [31:0] expWdata;
    logic [31:0] tmp;
    int          reads;
    int          writes;
    int          lat;
    logic [31:0] rdAddr;
    logic [31:0] wrAddr;
    logic [31:0] wrData;
    logic [31:0] rdata;
    logic        err;
    logic        readyInResp;

    n = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : (size == 2'd2) ? 4 : 0;
    if (n == 0) expErr = 1'b1;
    else        expErr = ((addr % n) != 0) || (we && n < 4 && addr >= 32'hFFFF_FFF0);
    aligned  = addr - (addr % 4);
    expRdata = 32'h0;
    expWdata = 32'h0;
    if (!expErr) begin
      if (we) begin
        for (int k = 0; k < n; k++) begin
          tmp = wdata >> (8 * k);
          refBytes[addr + 32'(k)] = tmp[7:0];
        end
        for (int k = 0; k < 4; k++) expWdata |= {24'h0, refByte(aligned + 32'(k))} << (8 * k);
      end else begin
        for (int k = 0; k < n; k++) expRdata |= {24'h0, refByte(addr + 32'(k))} << (8 * k);
        if (sgn && n < 4 && expRdata[8*n-1]) expRdata |= 32'hFFFF_FFFF << (8 * n);
      end
    end
    expLat    = expErr ? 1 : (!we ? 3 : (n == 4 ? 2 : 4));
    expReads  = (!expErr && (!we || n < 4)) ? 1 : 0;
    expWrites = (!expErr && we) ? 1 : 0;

    checkOutput({name, " ready_idle"}, 32'(bus.req_ready), 32'd1);
    bus.req_valid  = 1'b1;
    bus.req_we     = we;
    bus.req_size   = size;
    bus.req_signed = sgn;
    bus.req_addr   = addr;
    bus.req_wdata  = wdata;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    bus.req_addr  = $urandom;
    bus.req_wdata = $urandom;

    reads = 0; writes = 0; lat = 0;
    rdAddr = 'x; wrAddr = 'x; wrData = 'x; rdata = 'x; err = 1'bx; readyInResp = 1'bx;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      if (memread_o)  begin reads++;  rdAddr = memaddr_o; end
      if (memwrite_o) begin writes++; wrAddr = memaddr_o; wrData = memwdata_o; end
      if (bus.resp_valid) begin
        lat = c; rdata = bus.resp_rdata; err = bus.resp_err; readyInResp = bus.req_ready;
        break;
      end
    end

    checkOutput({name, " latency"}, 32'(lat), 32'(expLat));
    checkOutput({name, " err"}, 32'(err), 32'(expErr));
    checkOutput({name, " rdata"}, rdata, expRdata);
    checkOutput({name, " reads"}, 32'(reads), 32'(expReads));
    checkOutput({name, " writes"}, 32'(writes), 32'(expWrites));
    if (expReads == 1) checkOutput({name, " rd_addr"}, rdAddr, aligned);
    if (expWrites == 1) begin
      checkOutput({name, " wr_addr"}, wrAddr, aligned);
      checkOutput({name, " wr_data"}, wrData, expWdata);
    end
    if (lat != 0) begin
      checkOutput({name, " ready_in_resp"}, 32'(readyInResp), 32'd0);
      @(negedge clk);
      checkOutput({name, " resp_one_cycle"}, 32'(bus.resp_valid), 32'd0);
    end
  endtask

  initial begin
    int rstWrites;
    int rstResps;
    logic [1:0] rsize;

    bus.req_valid  = 1'b0;
    bus.req_we     = 1'b0;
    bus.req_size   = 2'd0;
    bus.req_signed = 1'b0;
    bus.req_addr   = 32'h0;
    bus.req_wdata  = 32'h0;

    // Reset, then check the idle state seen on the first cycle after it.
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    checkOutput("reset ready", 32'(bus.req_ready), 32'd1);
    checkOutput("reset resp_valid", 32'(bus.resp_valid), 32'd0);
    checkOutput("reset rdata", bus.resp_rdata, 32'h0);
    checkOutput("reset err", 32'(bus.resp_err), 32'd0);
    checkOutput("reset memread", 32'(memread_o), 32'd0);
    checkOutput("reset memwrite", 32'(memwrite_o), 32'd0);
    checkOutput("reset memaddr", memaddr_o, 32'h0);
    checkOutput("reset memwdata", memwdata_o, 32'h0);

    // Directed loads over the known word 0xDEADBEEF.
    applyStimulus(1'b0, 2'd2, 1'b0, 32'h0000_1004, 32'h0, "lw_1004");
    applyStimulus(1'b0, 2'd0, 1'b1, 32'h0000_1007, 32'h0, "lb_1007");
    applyStimulus(1'b0, 2'd0, 1'b0, 32'h0000_1007, 32'h0, "lbu_1007");
    applyStimulus(1'b0, 2'd1, 1'b1, 32'h0000_1006, 32'h0, "lh_1006");

    // Read-modify-write half store, then MMIO word store and rejected byte.
    applyStimulus(1'b1, 2'd1, 1'b0, 32'h0000_1002, 32'h0000_1234, "sh_1002");
    applyStimulus(1'b1, 2'd2, 1'b0, 32'hFFFF_FFF0, 32'h0000_0042, "sw_mmio");
    applyStimulus(1'b1, 2'd0, 1'b0, 32'hFFFF_FFF4, 32'h0000_0077, "sb_mmio");

    // Misaligned and illegal-size requests.
    applyStimulus(1'b0, 2'd2, 1'b0, 32'h0000_1001, 32'h0, "lw_misal");
    applyStimulus(1'b0, 2'd1, 1'b0, 32'h0000_1003, 32'h0, "lh_misal");
    applyStimulus(1'b0, 2'd3, 1'b0, 32'h0000_1000, 32'h0, "size3");

    // Byte store abandoned by a one-cycle reset during its WAIT cycle.
    bus.req_valid  = 1'b1;
    bus.req_we     = 1'b1;
    bus.req_size   = 2'd0;
    bus.req_signed = 1'b0;
    bus.req_addr   = 32'h0000_1001;
    bus.req_wdata  = 32'h0000_0099;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    rstWrites = 0;
    rstResps  = 0;
    for (int c = 1; c <= 7; c++) begin
      @(negedge clk);
      if (memwrite_o) rstWrites++;
      if (bus.resp_valid) rstResps++;
      if (c == 2) rst = 1'b1;
      if (c == 3) begin
        rst = 1'b0;
        checkOutput("rst_mid ready_after", 32'(bus.req_ready), 32'd1);
      end
    end
    checkOutput("rst_mid writes", 32'(rstWrites), 32'd0);
    checkOutput("rst_mid resps", 32'(rstResps), 32'd0);
    applyStimulus(1'b0, 2'd2, 1'b0, 32'h0000_1000, 32'h0, "lw_after_rst");

    // Randomised mix over a small RAM window and the MMIO window.
    for (int i = 0; i < 40; i++) begin
      rsize = ($urandom_range(7) == 0) ? 2'd3 : 2'($urandom_range(2));
      applyStimulus(1'($urandom_range(1)), rsize, 1'($urandom_range(1)),
                    ($urandom_range(5) == 0) ? 32'hFFFF_FFF0 + 32'($urandom_range(15))
                                             : 32'h0000_1000 + 32'($urandom_range(63)),
                    $urandom, $sformatf("rand%0d", i));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
